// File: rtl/constraint_sched_pkg.sv
// Shared types, defaults and helpers for the constraint-check scheduler.
package constraint_sched_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_VEC_W    = 64;
  localparam int DEF_EVAL_LAT = 1;
  localparam int DEF_CNT_W    = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_GRANT = 2'd1;
  localparam state_t S_EVAL  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  // Holds at the all-ones value of a w-bit counter instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [32:0] max_val;
    max_val = (33'd1 << w) - 33'd1;
    if ({1'b0, val} >= max_val) return val;
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/constraint_check_sched_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr.
module rr_arbiter
  import constraint_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic found;
  int   pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDW'(pos);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/constraint_check_sched.sv
// Time-shares one constraint evaluator between NREQ requesters, round-robin.
// Optional saturating pass/fail statistics: define CONSTRAINT_SCHED_STATS_EN.
module constraint_check_sched
  import constraint_sched_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int VEC_W    = DEF_VEC_W,
  parameter int EVAL_LAT = DEF_EVAL_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*VEC_W-1:0]   req_vec,
  output logic [VEC_W-1:0]        chk_vec,
  input  logic                    chk_x,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_pass,
  output logic                    busy,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt
);

  localparam int          IDW    = $clog2(NREQ);
  localparam logic [3:0]  LAT_LD = 4'(EVAL_LAT);

  state_t          state;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_next;
  logic [3:0]      wait_cnt;
  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            handshake;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign req_ready = (state == S_GRANT) ? gnt_oh : '0;
  assign handshake = |(req_valid & req_ready);
  assign busy      = (state != S_IDLE);
  assign rr_next   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt_idx   <= '0;
      gnt_oh    <= '0;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      chk_vec   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_pass  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            gnt_idx <= arb_idx;
            gnt_oh  <= arb_grant;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A requester that withdrew loses its turn without moving rr_ptr.
          if (handshake) begin
            chk_vec  <= req_vec[int'(gnt_idx)*VEC_W +: VEC_W];
            wait_cnt <= LAT_LD;
            state    <= S_EVAL;
          end else begin
            state <= S_IDLE;
          end
        end
        S_EVAL: begin
          if (wait_cnt == 4'd0) begin
            rsp_pass  <= chk_x;
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= rr_next;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONSTRAINT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (rsp_pass) pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), CNT_W));
      else          fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), CNT_W));
    end
  end
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule
